// File: rtl/calc_datapath.sv
// Calculator datapath: synchronises/qualifies the sequencer phase code, latches operands and
// runs ADD/SUB/AND (one cycle) or MUL (W-cycle shift-add, only when CALC_MUL_EN is defined).
module calc_datapath #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [1:0]     state,
  input  logic [W-1:0]   sw,
  input  logic [1:0]     op,
  output logic [2*W-1:0] result,
  output logic           busy,
  output logic           done,
  output logic           ovf
);

  localparam logic [1:0] PH_WAIT  = 2'b00;
  localparam logic [1:0] PH_LOAD1 = 2'b01;
  localparam logic [1:0] PH_LOAD2 = 2'b10;
  localparam logic [1:0] PH_CALC  = 2'b11;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b11;

`ifdef CALC_MUL_EN
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam int AW = 2 * W;
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
`else
  localparam int AW = W;
`endif

  typedef enum logic [1:0] {
    ENG_IDLE = 2'b00,
    ENG_RUN  = 2'b01,
    ENG_DONE = 2'b10
  } eng_t;

  logic [1:0]     sync1_r, sync2_r, acc_r;
  logic           entry_s;
  eng_t           eng_r;
  logic [W-1:0]   a_r, b_r;
  logic [1:0]     op_r;
  logic [AW-1:0]  opa_r;
  logic [W-1:0]   opb_r;
  logic [2*W-1:0] result_r;
  logic           busy_r, done_r, ovf_r;
  logic [2*W-1:0] fast_res_s;
  logic           fast_ovf_s;
`ifdef CALC_MUL_EN
  logic [AW-1:0]  prod_r;
  logic [AW-1:0]  addend_s;
  logic [CW-1:0]  cnt_r;
`endif

  // A code is accepted once both sync stages agree and it differs from the held code.
  assign entry_s = (sync1_r == sync2_r) && (sync2_r != acc_r);

  // Two-flop synchroniser plus the accepted phase code.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= PH_WAIT;
      sync2_r <= PH_WAIT;
      acc_r   <= PH_WAIT;
    end else begin
      sync1_r <= state;
      sync2_r <= sync1_r;
      if (entry_s) acc_r <= sync2_r;
    end
  end

  // Single-cycle operation results, selected by the op latched at CALCULATE entry.
  always_comb begin
    fast_res_s = {(2*W){1'b0}};
    fast_ovf_s = 1'b0;
    case (op_r)
      OP_ADD: fast_res_s = {{W{1'b0}}, opa_r[W-1:0]} + {{W{1'b0}}, opb_r};
      OP_SUB: begin
        fast_res_s = {{W{1'b0}}, opa_r[W-1:0]} - {{W{1'b0}}, opb_r};
        fast_ovf_s = (opb_r > opa_r[W-1:0]);
      end
      OP_AND: fast_res_s = {{W{1'b0}}, opa_r[W-1:0] & opb_r};
      default: begin
        fast_res_s = {(2*W){1'b0}};
        fast_ovf_s = 1'b1;
      end
    endcase
  end

`ifdef CALC_MUL_EN
  // Partial product for the current multiplier bit.
  always_comb begin
    addend_s = {AW{1'b0}};
    if (opb_r[0]) addend_s = opa_r;
    else          addend_s = {AW{1'b0}};
  end
`endif

  // Operand registers and the IDLE/RUN/DONE engine; WAIT entry overrides everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eng_r    <= ENG_IDLE;
      a_r      <= {W{1'b0}};
      b_r      <= {W{1'b0}};
      op_r     <= OP_ADD;
      opa_r    <= {AW{1'b0}};
      opb_r    <= {W{1'b0}};
      result_r <= {(2*W){1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      ovf_r    <= 1'b0;
`ifdef CALC_MUL_EN
      prod_r   <= {AW{1'b0}};
      cnt_r    <= {CW{1'b0}};
`endif
    end else if (entry_s && (sync2_r == PH_WAIT)) begin
      eng_r    <= ENG_IDLE;
      a_r      <= {W{1'b0}};
      b_r      <= {W{1'b0}};
      result_r <= {(2*W){1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      ovf_r    <= 1'b0;
    end else begin
      if (entry_s && (sync2_r == PH_LOAD1)) a_r <= sw;
      if (entry_s && (sync2_r == PH_LOAD2)) b_r <= sw;
      case (eng_r)
        ENG_IDLE: begin
          if (entry_s && (sync2_r == PH_CALC)) begin
            eng_r  <= ENG_RUN;
            busy_r <= 1'b1;
            op_r   <= op;
            opb_r  <= b_r;
`ifdef CALC_MUL_EN
            opa_r  <= {{W{1'b0}}, a_r};
            prod_r <= {AW{1'b0}};
            cnt_r  <= {CW{1'b0}};
`else
            opa_r  <= a_r;
`endif
          end
        end
        ENG_RUN: begin
`ifdef CALC_MUL_EN
          if ((op_r == OP_MUL) && (cnt_r != CNT_LAST)) begin
            prod_r <= prod_r + addend_s;
            opa_r  <= {opa_r[AW-2:0], 1'b0};
            opb_r  <= {1'b0, opb_r[W-1:1]};
            cnt_r  <= cnt_r + CNT_ONE;
          end else if (op_r == OP_MUL) begin
            result_r <= prod_r + addend_s;
            ovf_r    <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b1;
            eng_r    <= ENG_DONE;
          end else begin
`else
          begin
`endif
            result_r <= fast_res_s;
            ovf_r    <= fast_ovf_s;
            busy_r   <= 1'b0;
            done_r   <= 1'b1;
            eng_r    <= ENG_DONE;
          end
        end
        ENG_DONE: eng_r <= ENG_DONE;
        default: begin
          eng_r  <= ENG_IDLE;
          busy_r <= 1'b0;
          done_r <= 1'b0;
        end
      endcase
    end
  end

  assign result = result_r;
  assign busy   = busy_r;
  assign done   = done_r;
  assign ovf    = ovf_r;

endmodule

// File: tb/tb_calc_datapath.sv
// Self-checking bench for calc_datapath: directed scenarios plus randomized operation
// sequences checked against an arithmetic reference model.
module tb_calc_datapath;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [1:0]     state;
  logic [W-1:0]   sw;
  logic [1:0]     op;
  logic [2*W-1:0] result;
  logic           busy, done, ovf;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  logic [W-1:0]   ma, mb;
  logic [2*W-1:0] mres;
  logic           mdone, movf;
  logic [1:0]     mcur;

  calc_datapath #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .state(state), .sw(sw), .op(op),
    .result(result), .busy(busy), .done(done), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void ref_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] o,
                                 output logic [2*W-1:0] r, output logic v, output int cyc);
    int unsigned ai, bi;
    logic [31:0] t;
    ai = a; bi = b; v = 1'b0; cyc = 1; t = 32'd0;
    case (o)
      2'b00: t = ai + bi;
      2'b01: begin t = ai - bi; v = (bi > ai); end
      2'b10: begin
`ifdef CALC_MUL_EN
        t = ai * bi; cyc = W;
`else
        t = 32'd0; v = 1'b1;
`endif
      end
      default: t = ai & bi;
    endcase
    r = t[2*W-1:0];
  endfunction

  task automatic model_clear();
    ma = '0; mb = '0; mres = '0; mdone = 1'b0; movf = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, ".busy"}, 32'(busy), 32'(1'b0));
    check_eq({tag, ".done"}, 32'(done), 32'(mdone));
    check_eq({tag, ".result"}, 32'(result), 32'(mres));
    check_eq({tag, ".ovf"}, 32'(ovf), 32'(movf));
  endtask

  // Apply a non-CALCULATE phase code and let it settle.
  task automatic go(input logic [1:0] code, input logic [W-1:0] s);
    @(posedge clk); #1;
    state = code; sw = s;
    repeat (6) @(posedge clk);
    @(negedge clk);
    if (code != mcur) begin
      mcur = code;
      case (code)
        2'b00: model_clear();
        2'b01: ma = s;
        2'b10: mb = s;
        default: ;
      endcase
    end
    check_outputs($sformatf("go%0d", code));
  endtask

  // Apply CALCULATE and count busy cycles over a fixed window.
  task automatic calc(input logic [1:0] o, input string tag);
    logic [2*W-1:0] er;
    logic ev;
    int ec, nb;
    bit taken;
    taken = (mcur != 2'b11) && !mdone;
    ec = 0;
    if (taken) ref_op(ma, mb, o, er, ev, ec);
    @(posedge clk); #1;
    state = 2'b11; op = o;
    nb = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) nb++;
    end
    mcur = 2'b11;
    if (taken) begin mres = er; movf = ev; mdone = 1'b1; end
    check_eq({tag, ".busy_cycles"}, 32'(nb), 32'(ec));
    check_outputs(tag);
  endtask

  task automatic start_calc(input logic [1:0] o);
    @(posedge clk); #1;
    state = 2'b11; op = o;
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic [1:0]   ro;
    int           rm, nb;
    bit           seen;

    rst_n = 1'b0; state = 2'b01; sw = 8'h21; op = 2'b00;
    model_clear(); mcur = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs("reset");

    // Release with LOAD_FIRST already on the input: its entry must follow.
    @(posedge clk); #1; rst_n = 1'b1;
    nb = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (busy) nb++;
    end
    check_eq("post_reset.busy_cycles", 32'(nb), 32'd0);
    check_outputs("post_reset");
    mcur = 2'b01; ma = 8'h21;
    calc(2'b00, "post_reset_add");
    check_eq("post_reset_add.const", 32'(result), 32'h0021);

    go(2'b00, 8'h00); go(2'b01, 8'h0C); go(2'b10, 8'h05);
    calc(2'b00, "add_0c_05");
    check_eq("add_0c_05.const", 32'(result), 32'h0011);

    go(2'b00, 8'h00); go(2'b01, 8'h03); go(2'b10, 8'h07);
    calc(2'b01, "sub_03_07");
    check_eq("sub_03_07.const", 32'(result), 32'hFFFC);
    check_eq("sub_03_07.ovf_const", 32'(ovf), 32'd1);

    go(2'b00, 8'h00); go(2'b01, 8'hFF); go(2'b10, 8'hFF);
    calc(2'b10, "mul_ff_ff");
`ifdef CALC_MUL_EN
    check_eq("mul_ff_ff.const", 32'(result), 32'hFE01);
`else
    check_eq("mul_ff_ff.const", 32'(result), 32'h0000);
    check_eq("mul_ff_ff.ovf_const", 32'(ovf), 32'd1);
`endif

    // One-cycle transients between LOAD_FIRST and LOAD_SECOND must be ignored.
    for (int k = 0; k < 2; k++) begin
      go(2'b00, 8'h00); go(2'b01, 8'h11 + 8'(k * 8'h33));
      @(posedge clk); #1; state = (k == 0) ? 2'b11 : 2'b00; sw = 8'h22 + 8'(k);
      @(posedge clk); #1; state = 2'b10;
      nb = 0;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (busy) nb++;
      end
      check_eq("transient.busy_cycles", 32'(nb), 32'd0);
      check_eq("transient.done", 32'(done), 32'd0);
      mcur = 2'b10; mb = 8'h22 + 8'(k);
      calc(2'b00, "transient_add");
    end

`ifdef CALC_MUL_EN
    // WAIT entry aborts a multiply in flight; a fresh run follows.
    go(2'b00, 8'h00); go(2'b01, 8'h0F); go(2'b10, 8'h0E);
    start_calc(2'b10);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (busy) seen = 1'b1;
    end
    check_eq("abort.busy_seen", 32'(seen), 32'd1);
    repeat (2) @(negedge clk);
    check_eq("abort.result_during_run", 32'(result), 32'd0);
    @(posedge clk); #1; state = 2'b00;
    repeat (6) @(posedge clk);
    @(negedge clk);
    mcur = 2'b00; model_clear();
    check_outputs("abort");
    calc(2'b10, "abort_rerun");

    // Operand load during RUN must not disturb the running multiply.
    go(2'b00, 8'h00); go(2'b01, 8'h0D); go(2'b10, 8'h0B);
    start_calc(2'b10);
    repeat (2) @(posedge clk); #1;
    state = 2'b01; sw = 8'h77;
    repeat (20) @(posedge clk);
    @(negedge clk);
    mcur = 2'b01; ma = 8'h77; mres = 16'h008F; movf = 1'b0; mdone = 1'b1;
    check_outputs("load_during_run");
    go(2'b10, 8'h02);
    calc(2'b00, "calc_in_done_ignored");
`endif

    for (int it = 0; it < 24; it++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      ro = 2'($urandom_range(0, 3)); rm = $urandom_range(0, 3);
      go(2'b00, 8'($urandom)); go(2'b01, ra);
      if (rm != 0) go(2'b10, rb);
      calc(ro, $sformatf("rand%0d", it));
      if (rm == 3) begin
        go(2'b01, 8'($urandom));
        calc(ro, $sformatf("rand%0d_again", it));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/calc_datapath.md
CALC_DATAPATH -- requirements
Module: calc_datapath

Interface
REQ-001 Parameter W, default 8: operand width; result width is 2*W.
REQ-002 clk  input  1  single system clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 state  input  2  phase code from the button sequencer: 00 WAIT, 01 LOAD_FIRST, 10 LOAD_SECOND, 11 CALCULATE; asynchronous to clk.
REQ-005 sw  input  W  operand source switches; sampled only on phase entry.
REQ-006 op  input  2  operation select: 00 ADD, 01 SUB, 10 MUL, 11 AND.
REQ-007 result  output  2*W  computed value; held until cleared.
REQ-008 busy  output  1  high while an operation is executing.
REQ-009 done  output  1  level; high from completion until the next WAIT entry.
REQ-010 ovf  output  1  error/overflow flag; valid when done is high.

Function
REQ-011 state SHALL pass through a 2-flop synchronizer; a third register SHALL hold the last accepted code.
REQ-012 Qualification: a new code is accepted only when the synchronized value is unchanged for 2 consecutive cycles and differs from the accepted code; transient codes during multi-bit changes (01->10) are ignored.
REQ-013 Phase entry event: a single-cycle internal pulse in the cycle the accepted code updates; worst-case input-to-event latency is 4 clk cycles.
REQ-014 LOAD_FIRST entry SHALL capture sw into operand A; LOAD_SECOND entry SHALL capture sw into operand B.
REQ-015 CALCULATE entry SHALL capture op and move the engine from IDLE to RUN; the engine ignores CALCULATE entry outside IDLE.
REQ-016 WAIT entry SHALL clear A, B, result, done and ovf, abort RUN, and return the engine to IDLE within the same cycle, from any engine state.
REQ-017 Engine states: IDLE (busy=0, done=0), RUN (busy=1, done=0), DONE (busy=0, done=1). Transitions: IDLE->RUN on CALCULATE entry; RUN->DONE on completion; DONE->IDLE only on WAIT entry; any->IDLE on WAIT entry.
REQ-018 ADD: result = zero-extended A+B; ovf=0; 1 RUN cycle.
REQ-019 SUB: result = A-B as a 2*W two's-complement value; ovf=1 when B>A (unsigned borrow); 1 RUN cycle.
REQ-020 AND: result = zero-extended A&B; ovf=0; 1 RUN cycle.
REQ-021 MUL: unsigned iterative shift-add, one multiplier bit per cycle, exactly W RUN cycles; result = A*B; ovf=0.
REQ-022 result, done and ovf SHALL update together on the RUN->DONE edge; result SHALL not change during RUN.
REQ-023 CALCULATE entry without a preceding LOAD_SECOND SHALL operate on the currently held A and B.
REQ-024 LOAD_FIRST or LOAD_SECOND entry during RUN or DONE SHALL update the operand register only; an in-flight operation uses the values latched at CALCULATE entry.

Reset
REQ-025 While rst_n=0: result=0, busy=0, done=0, ovf=0, A=B=0, engine IDLE, synchronizer and accepted code = 00 (WAIT).
REQ-026 Reset deassertion during a non-WAIT input code SHALL produce that code's entry event after qualification; no operation starts without a CALCULATE entry.

Configuration
REQ-027 Macro CALC_MUL_EN defined: MUL is implemented per REQ-021.
REQ-028 CALC_MUL_EN undefined: no multiplier logic is present; op=10 SHALL complete in 1 RUN cycle with result=0 and ovf=1.

Verification
REQ-029 Reset, then state 01 with sw=0x0C, 10 with sw=0x05, 11 with op=00 -> done=1, result=0x0011, ovf=0, busy high exactly 1 cycle.
REQ-030 A=0x03, B=0x07, op=01 -> result=0xFFFC, ovf=1.
REQ-031 CALC_MUL_EN defined, A=0xFF, B=0xFF, op=10 -> busy high exactly 8 cycles, then result=0xFE01, ovf=0; with the macro undefined -> result=0x0000, ovf=1 after 1 cycle.
REQ-032 MUL in progress, state driven to 00 mid-RUN -> busy=0, done=0, result=0 within the cycle of the WAIT entry event; a later CALCULATE entry starts a fresh run.
REQ-033 state changed 01->10 with the bit flips 1 cycle apart (transient 11 or 00 for 1 cycle) -> only LOAD_SECOND is accepted; no CALCULATE or WAIT effect.
